// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder and the
// datapath that drives it.
//   state_t     : responder FSM states (IDLE, WAIT, RBEAT, WBEAT, DONE)
//   LEN_W       : width of the burst length / beat counter fields
//   MAX_BEATS   : longest burst (LM/SM move eight words)
//   DEF_ADDR_W  : default word-address width, shared with the datapath
//   DEF_DATA_W  : default data word width, shared with the datapath
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int LEN_W      = 3;
  localparam int MAX_BEATS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RBEAT = 3'd2,
    ST_WBEAT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word RAM, DEPTH x DATA_W, synchronous write and
// synchronous read, no reset (contents survive a processor reset).
// Ports:
//   clk   in   clock
//   we    in   write addr with wdata on this edge
//   re    in   capture mem[addr] into rdata on this edge
//   addr  in   word address
//   wdata in   write data
//   rdata out  registered read data (valid the cycle after re)
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle 16-bit processor.
// Serves LW/SW single beats and LM/SM bursts of up to 8 words against an
// internal word-addressed RAM, with WAIT_CYC idle cycles between request
// accept and the first beat.
// Optional feature: define MEM_WRITE_PROTECT_EN to make words [0, ROM_TOP)
// read-only; a write beat there is handshaken but dropped and sets the
// sticky err flag. Without the macro every word is writable and err is 0.
// Ports:
//   clk, proc_rst          clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (req_we, req_addr, req_len)
//   wr_data/wr_valid/wr_ready  write beat handshake
//   rd_data/rd_valid       read beats, no backpressure
//   done                   one-cycle pulse at burst completion
//   err                    sticky write-protect violation
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. req_ready is high only in IDLE; wr_ready only in WBEAT. Ready
// never depends on valid, so the initiator may hold valid as long as it likes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 1,
  parameter int ROM_TOP  = 64
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic              we_q;
  logic [ADDR_W-1:0] start_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  wait_cnt;
  logic              rd_valid_q;
  logic [DATA_W-1:0] ram_q;

  // Natural ADDR_W truncation gives the wrap past the top address.
  logic [ADDR_W-1:0] beat_addr;
  logic              wr_fire;
  logic              wr_blocked;

  assign beat_addr = start_q + ADDR_W'(beat_q);
  assign wr_fire   = (state == ST_WBEAT) && wr_valid;

`ifdef MEM_WRITE_PROTECT_EN
  localparam logic [ADDR_W:0] ROM_TOP_W = (ADDR_W+1)'(ROM_TOP);
  logic err_q;

  assign wr_blocked = ({1'b0, beat_addr} < ROM_TOP_W);

  always_ff @(posedge clk) begin
    if (proc_rst)                  err_q <= 1'b0;
    else if (wr_fire && wr_blocked) err_q <= 1'b1;
  end

  assign err = err_q && !proc_rst;
`else
  assign wr_blocked = 1'b0;
  assign err        = 1'b0;
`endif

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    // Reset abandons the burst, so a beat presented under reset never lands.
    .we    (wr_fire && !wr_blocked && !proc_rst),
    .re    (state == ST_RBEAT),
    .addr  (beat_addr),
    .wdata (wr_data),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_cnt   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      // Array read issued in RBEAT returns one cycle later.
      rd_valid_q <= (state == ST_RBEAT);
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            start_q  <= req_addr;
            len_q    <= req_len;
            beat_q   <= '0;
            wait_cnt <= '0;
            if (WAIT_CYC > 0) state <= ST_WAIT;
            else              state <= req_we ? ST_WBEAT : ST_RBEAT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LEN_W'(WAIT_CYC - 1)) state <= we_q ? ST_WBEAT : ST_RBEAT;
          else                                  wait_cnt <= wait_cnt + 1'b1;
        end
        ST_RBEAT: begin
          // Compare before incrementing so len=7 never needs beat 8.
          if (beat_q == len_q) state <= ST_DONE;
          else                 beat_q <= beat_q + 1'b1;
        end
        ST_WBEAT: begin
          if (wr_valid) begin
            if (beat_q == len_q) state <= ST_DONE;
            else                 beat_q <= beat_q + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; the reset term forces them low for the
  // whole reset window, including the cycle reset is first applied.
  assign req_ready = (state == ST_IDLE)  && !proc_rst;
  assign wr_ready  = (state == ST_WBEAT) && !proc_rst;
  assign done      = (state == ST_DONE)  && !proc_rst;
  assign rd_valid  = rd_valid_q && !proc_rst;
  assign rd_data   = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder.
// A word-array model plus queues of expected read beats (data and the cycle
// each must appear in) are derived from the request stream; a monitor checks
// every rd_valid beat and records done pulses.
module tb_mem_responder;

  localparam int WAIT_CYC = 1;
  localparam int ROM_TOP  = 64;

  logic        clk = 1'b0;
  logic        proc_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [2:0]  req_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;

  mem_responder #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .DEPTH    (256),
    .WAIT_CYC (WAIT_CYC),
    .ROM_TOP  (ROM_TOP)
  ) dut (
    .clk       (clk),
    .proc_rst  (proc_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rd_cnt = 0;

  // ---------------- reference model ----------------
  logic [15:0] model [256];
  bit          known [256];
  bit          exp_err = 1'b0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          exp_known_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [15:0] wbuf [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin : mon
    logic [15:0] d;
    logic [7:0]  a;
    int          c;
    bit          k;
    cyc++;
    #1;
    if (rd_valid) begin
      rd_cnt++;
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        k = exp_known_q.pop_front();
        a = exp_addr_q.pop_front();
        if (k) check("rd_data", {16'd0, rd_data}, {16'd0, d});
        else begin
          // Never-writable word: its power-up content becomes the reference.
          model[a] = rd_data;
          known[a] = 1'b1;
        end
        check("rd_cycle", c, cyc);
      end
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic issue(input bit we, input logic [7:0] addr, input logic [2:0] len,
                       output int acc);
    int g = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    while (!req_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("req_accept_timeout", g, 0);
    acc = cyc;
    if (!we) begin
      for (int i = 0; i <= int'(len); i++) begin
        logic [7:0] a;
        a = addr + 8'(i);
        exp_q.push_back(model[a]);
        exp_known_q.push_back(known[a]);
        exp_addr_q.push_back(a);
        exp_cyc_q.push_back(acc + WAIT_CYC + 2 + i);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output int dcyc);
    int g = 0;
    while (done_cnt < target && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) check("done_timeout", g, 0);
    dcyc = last_done_cyc;
  endtask

  task automatic read_burst(input logic [7:0] addr, input logic [2:0] len);
    int prev = done_cnt;
    int acc, dc;
    issue(1'b0, addr, len, acc);
    wait_done(prev + 1, dc);
    check("rd_done_cycle", dc, acc + WAIT_CYC + 2 + int'(len));
    check("rd_all_beats", exp_q.size(), 0);
  endtask

  task automatic write_burst(input logic [7:0] addr, input logic [2:0] len,
                             input int stall_beat, input int stall_n, input bit rnd);
    int prev = done_cnt;
    int acc, dc;
    int i = 0;
    int g = 0;
    int left = stall_n;
    int last_hs = 0;
    issue(1'b1, addr, len, acc);
    while (i <= int'(len) && g < 300) begin
      wr_data = wbuf[i];
      if (wr_ready && i == stall_beat && left > 0) begin
        wr_valid = 1'b0;
        left--;
      end else if (rnd && $urandom_range(0, 3) == 0) wr_valid = 1'b0;
      else wr_valid = 1'b1;
      if (wr_valid && wr_ready) begin
        logic [7:0] a;
        a = addr + 8'(i);
`ifdef MEM_WRITE_PROTECT_EN
        if (a < 8'(ROM_TOP)) exp_err = 1'b1;
        else begin
          model[a] = wbuf[i];
          known[a] = 1'b1;
        end
`else
        model[a] = wbuf[i];
        known[a] = 1'b1;
`endif
        last_hs = cyc;
        i++;
      end
      @(negedge clk);
      g++;
    end
    wr_valid = 1'b0;
    if (i <= int'(len)) check("wr_beat_timeout", i, int'(len) + 1);
    wait_done(prev + 1, dc);
    check("wr_done_cycle", dc, last_hs + 1);
    if (!rnd) check("wr_latency", dc, acc + WAIT_CYC + 2 + int'(len) + stall_n);
  endtask

  task automatic reset_mid_read();
    int acc, g, r0;
    g = 0;
    issue(1'b0, 8'h20, 3'd7, acc);
    while (exp_q.size() > 5 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("rst_three_beats_seen", exp_q.size(), 5);
    proc_rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    exp_known_q.delete();
    exp_addr_q.delete();
    exp_err = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst_outputs", {req_ready, wr_ready, rd_valid, done, err}, 0);
      check("rst_rd_data", {16'd0, rd_data}, 0);
    end
    @(negedge clk);
    proc_rst = 1'b0;
    #1;
    check("rst_ready_after", req_ready, 1);
    check("rst_other_outs", {wr_ready, rd_valid, done, err}, 0);
    r0 = rd_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_more_rd", rd_cnt, r0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc_a, acc_b, prev, dc;
    proc_rst  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("init_rst_outputs", {req_ready, wr_ready, rd_valid, done, err}, 0);
    proc_rst = 1'b0;
    #1;
    check("init_ready", req_ready, 1);
    @(negedge clk);

    // Fill the whole array so every later read has a known answer.
    for (int b = 0; b < 32; b++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = 16'($urandom);
      write_burst(8'(b * 8), 3'd7, 8, 0, 1'b1);
    end

    reset_mid_read();
    check("err_after_reset", err, 0);

    // Single SW/LW with latency checks.
    wbuf[0] = 16'hBEEF;
    write_burst(8'h40, 3'd0, 8, 0, 1'b0);
    read_burst(8'h40, 3'd0);

    // 8-beat write with a 2-cycle stall at beat 3, then readback.
    for (int j = 0; j < 8; j++) wbuf[j] = 16'h1000 + 16'(j);
    write_burst(8'h80, 3'd7, 3, 2, 1'b0);
    read_burst(8'h80, 3'd7);

    // Wrap past the top address.
    for (int j = 0; j < 8; j++) wbuf[j] = 16'($urandom);
    write_burst(8'hFE, 3'd3, 8, 0, 1'b0);
    read_burst(8'hFE, 3'd3);
    read_burst(8'h00, 3'd1);

    // Second request held while the first burst runs.
    prev = done_cnt;
    issue(1'b0, 8'h80, 3'd7, acc_a);
    issue(1'b0, 8'h40, 3'd0, acc_b);
    check("busy_accept_cycle", acc_b, acc_a + WAIT_CYC + 2 + 7 + 1);
    wait_done(prev + 2, dc);
    check("busy_done_count", done_cnt, prev + 2);
    check("busy_all_beats", exp_q.size(), 0);

    // Random mix of bursts.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] a;
      logic [2:0] l;
      a = 8'($urandom);
      l = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 8; j++) wbuf[j] = 16'($urandom);
        write_burst(a, l, 8, 0, 1'b1);
      end else begin
        read_burst(a, l);
      end
    end

`ifdef MEM_WRITE_PROTECT_EN
    proc_rst = 1'b1;
    exp_err  = 1'b0;
    @(negedge clk);
    proc_rst = 1'b0;
    @(negedge clk);
    check("prot_err_cleared", err, 0);
    read_burst(8'h10, 3'd0);
    wbuf[0] = 16'h1234;
    write_burst(8'h10, 3'd0, 8, 0, 1'b0);
    check("prot_err_set", err, 1);
    read_burst(8'h10, 3'd0);
    repeat (5) @(negedge clk);
    check("prot_err_sticky", err, 1);
`endif

    check("err_final", err, exp_err);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
